// File: rtl/verificador_disparo.sv
// Battleship shot checker: loads a 5x7 ship map, judges each fired coordinate and tracks hits/shots.
// Optional shot limit (loss condition) enabled by defining LIMITE_DISPAROS_EN.
module verificador_disparo #(
  parameter int MAX_DISPAROS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       disparar,
  output logic       acerto,
  output logic       erro,
  output logic       repetido,
  output logic       invalido,
  output logic [6:0] atingidos0,
  output logic [6:0] atingidos1,
  output logic [6:0] atingidos2,
  output logic [6:0] atingidos3,
  output logic [6:0] atingidos4,
  output logic [5:0] disparos,
  output logic [5:0] restantes,
  output logic       ocupado,
  output logic       fim_jogo,
  output logic       derrota
);

`ifdef LIMITE_DISPAROS_EN
  localparam logic LIMITE_ATIVO = 1'b1;
`else
  localparam logic LIMITE_ATIVO = 1'b0;
`endif
  localparam logic [5:0] LIMITE = 6'(MAX_DISPAROS);

  typedef enum logic [2:0] {OCIOSO, CARREGA, AGUARDA, AVALIA, FIM} estado_t;

  estado_t     estado_q, estado_d;
  logic        disparar_q;
  logic [2:0]  linha_q, linha_d;
  logic [2:0]  coluna_q, coluna_d;
  logic [34:0] atingidos_q, atingidos_d;
  logic [34:0] tentados_q, tentados_d;
  logic [5:0]  disparos_q, disparos_d;
  logic [5:0]  restantes_q, restantes_d;
  logic        acerto_q, acerto_d;
  logic        erro_q, erro_d;
  logic        repetido_q, repetido_d;
  logic        invalido_q, invalido_d;
  logic        fim_q, fim_d;
  logic        derrota_q, derrota_d;

  logic [34:0] mapa_flat;
  logic [5:0]  indice;
  logic [5:0]  total_navios;
  logic [5:0]  disparos_inc;
  logic        borda;

  function automatic logic [5:0] popcount35(input logic [34:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 35; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Cell (r,c) lives at bit r*7+c of the flattened map and masks.
  assign mapa_flat    = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign indice       = 6'(linha_q) * 6'd7 + 6'(coluna_q);
  assign total_navios = popcount35(mapa_flat);
  assign disparos_inc = (disparos_q == 6'd63) ? 6'd63 : disparos_q + 6'd1;
  assign borda        = disparar & ~disparar_q;

  always_comb begin
    estado_d    = estado_q;
    linha_d     = linha_q;
    coluna_d    = coluna_q;
    atingidos_d = atingidos_q;
    tentados_d  = tentados_q;
    disparos_d  = disparos_q;
    restantes_d = restantes_q;
    acerto_d    = 1'b0;
    erro_d      = 1'b0;
    repetido_d  = 1'b0;
    invalido_d  = 1'b0;
    fim_d       = fim_q;
    derrota_d   = derrota_q;

    if (!enable) begin
      estado_d  = OCIOSO;
      fim_d     = 1'b0;
      derrota_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: estado_d = CARREGA;
        CARREGA: begin
          restantes_d = total_navios;
          atingidos_d = '0;
          tentados_d  = '0;
          disparos_d  = '0;
          derrota_d   = 1'b0;
          fim_d       = (total_navios == 6'd0);
          estado_d    = (total_navios == 6'd0) ? FIM : AGUARDA;
        end
        AGUARDA: begin
          if (borda) begin
            linha_d  = linha;
            coluna_d = coluna;
            estado_d = AVALIA;
          end
        end
        AVALIA: begin
          estado_d = AGUARDA;
          if (linha_q > 3'd4 || coluna_q > 3'd6) begin
            invalido_d = 1'b1;
          end else if (tentados_q[indice]) begin
            repetido_d = 1'b1;
          end else begin
            tentados_d[indice] = 1'b1;
            disparos_d         = disparos_inc;
            if (mapa_flat[indice]) begin
              acerto_d            = 1'b1;
              atingidos_d[indice] = 1'b1;
              restantes_d         = restantes_q - 6'd1;
              if (restantes_q == 6'd1) begin
                fim_d    = 1'b1;
                estado_d = FIM;
              end
            end else begin
              erro_d = 1'b1;
            end
            // A shot that sinks the last ship wins even if it also reaches the limit.
            if (LIMITE_ATIVO && disparos_d == LIMITE && restantes_d != 6'd0) begin
              derrota_d = 1'b1;
              estado_d  = FIM;
            end
          end
        end
        FIM:     estado_d = FIM;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      disparar_q  <= 1'b0;
      linha_q     <= '0;
      coluna_q    <= '0;
      atingidos_q <= '0;
      tentados_q  <= '0;
      disparos_q  <= '0;
      restantes_q <= '0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      repetido_q  <= 1'b0;
      invalido_q  <= 1'b0;
      fim_q       <= 1'b0;
      derrota_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      disparar_q  <= disparar;
      linha_q     <= linha_d;
      coluna_q    <= coluna_d;
      atingidos_q <= atingidos_d;
      tentados_q  <= tentados_d;
      disparos_q  <= disparos_d;
      restantes_q <= restantes_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      repetido_q  <= repetido_d;
      invalido_q  <= invalido_d;
      fim_q       <= fim_d;
      derrota_q   <= derrota_d;
    end
  end

  assign acerto     = acerto_q;
  assign erro       = erro_q;
  assign repetido   = repetido_q;
  assign invalido   = invalido_q;
  assign atingidos0 = atingidos_q[6:0];
  assign atingidos1 = atingidos_q[13:7];
  assign atingidos2 = atingidos_q[20:14];
  assign atingidos3 = atingidos_q[27:21];
  assign atingidos4 = atingidos_q[34:28];
  assign disparos   = disparos_q;
  assign restantes  = restantes_q;
  assign ocupado    = (estado_q == AVALIA);
  assign fim_jogo   = fim_q;
  assign derrota    = derrota_q;

endmodule

// File: tb/tb_verificador_disparo.sv
// Directed self-checking bench for verificador_disparo; shot-limit checks follow LIMITE_DISPAROS_EN.
module tb_verificador_disparo;

`ifdef LIMITE_DISPAROS_EN
  localparam int TB_MAX = 3;
`else
  localparam int TB_MAX = 20;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] linha, coluna;
  logic       disparar;
  logic       acerto, erro, repetido, invalido;
  logic [6:0] atingidos0, atingidos1, atingidos2, atingidos3, atingidos4;
  logic [5:0] disparos, restantes;
  logic       ocupado, fim_jogo, derrota;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  verificador_disparo #(.MAX_DISPAROS(TB_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .linha(linha), .coluna(coluna), .disparar(disparar),
    .acerto(acerto), .erro(erro), .repetido(repetido), .invalido(invalido),
    .atingidos0(atingidos0), .atingidos1(atingidos1), .atingidos2(atingidos2),
    .atingidos3(atingidos3), .atingidos4(atingidos4),
    .disparos(disparos), .restantes(restantes),
    .ocupado(ocupado), .fim_jogo(fim_jogo), .derrota(derrota)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Called at a negedge: fires one shot and returns {fim_jogo, acerto, erro, repetido, invalido}
  // sampled when the result pulse is due; also checks the pulse is gone one cycle later.
  task automatic shot(input logic [2:0] l, input logic [2:0] c, output logic [4:0] res);
    linha = l; coluna = c; disparar = 1'b1;
    @(negedge clk);
    disparar = 1'b0;
    @(negedge clk);
    res = {fim_jogo, acerto, erro, repetido, invalido};
    @(negedge clk);
    check_value("pulse_cleared", {acerto, erro, repetido, invalido}, 4'b0000);
  endtask

  function automatic logic [34:0] hit_mask();
    return {atingidos4, atingidos3, atingidos2, atingidos1, atingidos0};
  endfunction

  logic [4:0] res;
  int         pulses;
  logic [2:0] cell_r [13] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
  logic [2:0] cell_c [13] = '{3'd2, 3'd2, 3'd3, 3'd0, 3'd2, 3'd6, 3'd0, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd6};

  initial begin
    reset_n = 1'b0; enable = 1'b0; disparar = 1'b0; linha = '0; coluna = '0;
    mapa0 = 7'b0000100; mapa1 = 7'b0001100; mapa2 = 7'b1000101;
    mapa3 = 7'b1110001; mapa4 = 7'b1000011;
    @(negedge clk); @(negedge clk);
    check_value("reset_pulses", {acerto, erro, repetido, invalido, ocupado, fim_jogo, derrota}, 7'b0);
    check_value("reset_counts", {disparos, restantes}, 12'h000);
    check_value("reset_mask", hit_mask(), 35'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Load the map: OCIOSO -> CARREGA -> AGUARDA
    enable = 1'b1;
    @(negedge clk); @(negedge clk);
    check_value("load_restantes", restantes, 6'd13);
    check_value("load_disparos", disparos, 6'd0);

    shot(3'd0, 3'd2, res);
    check_value("hit_0_2", res, 5'b01000);
    check_value("hit_mask0", atingidos0, 7'b0000100);
    check_value("hit_counts", {disparos, restantes}, {6'd1, 6'd12});
    shot(3'd0, 3'd0, res);
    check_value("miss_0_0", res, 5'b00100);
    check_value("miss_disparos", disparos, 6'd2);
    shot(3'd0, 3'd2, res);
    check_value("repeat_0_2", res, 5'b00010);
    shot(3'd5, 3'd0, res);
    check_value("invalid_row5", res, 5'b00001);
    shot(3'd0, 3'd7, res);
    check_value("invalid_col7", res, 5'b00001);
    check_value("rej_counts", {disparos, restantes}, {6'd2, 6'd12});
    check_value("rej_mask0", atingidos0, 7'b0000100);

    // Level held high for 10 cycles must produce a single result
    linha = 3'd1; coluna = 3'd2; disparar = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 10) disparar = 1'b0;
      pulses += int'(acerto) + int'(erro) + int'(repetido) + int'(invalido);
    end
    check_value("hold_pulses", pulses, 1);
    check_value("hold_restantes", restantes, 6'd11);

    // Reset in the middle of AVALIA discards the shot
    linha = 3'd2; coluna = 3'd2; disparar = 1'b1;
    @(negedge clk);
    check_value("ocupado_avalia", ocupado, 1'b1);
    disparar = 1'b0;
    reset_n = 1'b0;
    #1;
    check_value("rst_avalia_flags", {acerto, erro, repetido, invalido, ocupado, fim_jogo, derrota}, 7'b0);
    check_value("rst_avalia_counts", {disparos, restantes}, 12'h000);
    check_value("rst_avalia_mask", hit_mask(), 35'b0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(acerto) + int'(erro) + int'(repetido) + int'(invalido);
    end
    check_value("rst_no_pulse", pulses, 0);
    check_value("reload_restantes", restantes, 6'd13);

    // Sink every ship; last hit coincides with fim_jogo
    for (int i = 0; i < 13; i++) begin
      shot(cell_r[i], cell_c[i], res);
      check_value($sformatf("sink_%0d_%0d", cell_r[i], cell_c[i]), res,
                  (i == 12) ? 5'b11000 : 5'b01000);
    end
    check_value("sink_mask", hit_mask(), {mapa4, mapa3, mapa2, mapa1, mapa0});
    check_value("sink_counts", {disparos, restantes}, {6'd13, 6'd0});
    shot(3'd0, 3'd0, res);
    check_value("fim_ignores_edge", res, 5'b10000);
    check_value("fim_disparos", disparos, 6'd13);
    enable = 1'b0;
    @(negedge clk);
    check_value("disable_fim_clr", fim_jogo, 1'b0);
    check_value("disable_mask_hold", hit_mask(), {mapa4, mapa3, mapa2, mapa1, mapa0});

    // Three misses: loss only when the shot limit is built in
    enable = 1'b1;
    @(negedge clk); @(negedge clk);
    shot(3'd0, 3'd0, res);
    shot(3'd0, 3'd1, res);
    shot(3'd0, 3'd3, res);
    check_value("third_miss", res, 5'b00100);
    check_value("limit_disparos", disparos, 6'd3);
`ifdef LIMITE_DISPAROS_EN
    check_value("limit_derrota", {derrota, fim_jogo}, 2'b10);
    shot(3'd0, 3'd2, res);
    check_value("limit_locked", res, 5'b00000);
`else
    check_value("nolimit_derrota", {derrota, fim_jogo}, 2'b00);
`endif
    enable = 1'b0;
    @(negedge clk);
    check_value("disable_derrota_clr", derrota, 1'b0);

    // Empty map goes straight to FIM
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    enable = 1'b1;
    @(negedge clk); @(negedge clk);
    check_value("empty_fim", {fim_jogo, restantes}, {1'b1, 6'd0});

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
